// File: rtl/rv_pkg.sv
// Shared RV core definitions: datapath width, ALU opcodes, operand select codes
// and the ID/EX pipeline register payload.
package rv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned ALU_OP_W = 5;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned FUNCT3_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'b00000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'b00001;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'b00010;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'b00011;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'b00100;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'b00101;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'b00110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'b00111;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'b01000;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'b01001;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'b01010;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'b01011;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'b01100;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'b01101;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'b01110;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'b01111;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'b10000;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'b10001;
    localparam logic [ALU_OP_W-1:0] ALU_SRC1   = 5'b10010;

    localparam logic [SEL_W-1:0] SRC0_RS1  = 2'b00;
    localparam logic [SEL_W-1:0] SRC0_PC   = 2'b01;
    localparam logic [SEL_W-1:0] SRC0_ZERO = 2'b10;
    localparam logic [SEL_W-1:0] SRC1_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRC1_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRC1_FOUR = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic [SEL_W-1:0]    src0_sel;
        logic [SEL_W-1:0]    src1_sel;
        logic                reg_we;
        logic                mem_re;
        logic                mem_we;
        logic [FUNCT3_W-1:0] funct3;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks the youngest in-flight producer of a register (MEM over WB),
// never bypassing x0.
module fwd_mux
    import rv_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rs_data,
    input  logic             mem_we,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  fwd_data
);

    always_comb begin
        fwd_data = rs_data;
        if (rs != '0 && mem_we && mem_rd == rs) begin
            fwd_data = mem_data;
        end else if (rs != '0 && wb_we && wb_rd == rs) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection and load-use/RAW hazard stall.
// Define FWD_EN to enable MEM/WB forwarding; otherwise any RAW hazard stalls decode.
module id_ex_stage
    import rv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [SEL_W-1:0]    id_src0_sel,
    input  logic [SEL_W-1:0]    id_src1_sel,
    input  logic                id_reg_we,
    input  logic                id_mem_re,
    input  logic                id_mem_we,
    input  logic [FUNCT3_W-1:0] id_funct3,
    input  logic                mem_fwd_we,
    input  logic [REG_W-1:0]    mem_fwd_rd,
    input  logic [XLEN-1:0]     mem_fwd_data,
    input  logic                wb_fwd_we,
    input  logic [REG_W-1:0]    wb_fwd_rd,
    input  logic [XLEN-1:0]     wb_fwd_data,
    output logic [XLEN-1:0]     alu_src0,
    output logic [XLEN-1:0]     alu_src1,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ex_valid,
    output logic                ex_reg_we,
    output logic                ex_mem_re,
    output logic                ex_mem_we,
    output logic [REG_W-1:0]    ex_rd,
    output logic [FUNCT3_W-1:0] ex_funct3,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_store_data,
    output logic                load_use_stall
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    id_ex_t          cap;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // Decode slot payload; control bits are qualified so an invalid slot has no side effects
    always_comb begin
        cap          = '0;
        cap.valid    = id_valid;
        cap.pc       = id_pc;
        cap.rs1_data = id_rs1_data;
        cap.rs2_data = id_rs2_data;
        cap.imm      = id_imm;
        cap.rs1      = id_rs1;
        cap.rs2      = id_rs2;
        cap.rd       = id_rd;
        cap.alu_op   = id_alu_op;
        cap.src0_sel = id_src0_sel;
        cap.src1_sel = id_src1_sel;
        cap.reg_we   = id_reg_we & id_valid;
        cap.mem_re   = id_mem_re & id_valid;
        cap.mem_we   = id_mem_we & id_valid;
        cap.funct3   = id_funct3;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d = '0;
        end else begin
            ex_d = cap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef FWD_EN
    fwd_mux u_fwd_rs1 (
        .rs       (ex_q.rs1),
        .rs_data  (ex_q.rs1_data),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_fwd_we),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .fwd_data (rs1_fwd)
    );

    fwd_mux u_fwd_rs2 (
        .rs       (ex_q.rs2),
        .rs_data  (ex_q.rs2_data),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_fwd_we),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .fwd_data (rs2_fwd)
    );

    // Only a load in EX cannot be bypassed in time
    assign load_use_stall = id_valid & ex_q.valid & ex_q.mem_re & (ex_q.rd != '0)
                          & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
`else
    logic rs1_hit;
    logic rs2_hit;
    logic unused_fwd;

    assign rs1_fwd = ex_q.rs1_data;
    assign rs2_fwd = ex_q.rs2_data;

    // WB needs no stall: the register file is write-first
    assign rs1_hit = (id_rs1 != '0)
                   & ((ex_q.valid & ex_q.reg_we & (ex_q.rd == id_rs1))
                   | (mem_fwd_we & (mem_fwd_rd == id_rs1)));
    assign rs2_hit = (id_rs2 != '0)
                   & ((ex_q.valid & ex_q.reg_we & (ex_q.rd == id_rs2))
                   | (mem_fwd_we & (mem_fwd_rd == id_rs2)));
    assign load_use_stall = id_valid & (rs1_hit | rs2_hit);

    assign unused_fwd = ^{wb_fwd_we, wb_fwd_rd, wb_fwd_data, mem_fwd_data, ex_q.rs1, ex_q.rs2};
`endif

    always_comb begin
        alu_src0 = '0;
        case (ex_q.src0_sel)
            SRC0_RS1: alu_src0 = rs1_fwd;
            SRC0_PC:  alu_src0 = ex_q.pc;
            default:  alu_src0 = '0;
        endcase
    end

    always_comb begin
        alu_src1 = '0;
        case (ex_q.src1_sel)
            SRC1_RS2:  alu_src1 = rs2_fwd;
            SRC1_IMM:  alu_src1 = ex_q.imm;
            SRC1_FOUR: alu_src1 = XLEN'(4);
            default:   alu_src1 = '0;
        endcase
    end

    assign alu_op        = ex_q.alu_op;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_we     = ex_q.reg_we;
    assign ex_mem_re     = ex_q.mem_re;
    assign ex_mem_we     = ex_q.mem_we;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_pc         = ex_q.pc;
    assign ex_store_data = rs2_fwd;

endmodule
